// File: rtl/rr_pack_pkg.sv
// Shared types and helpers for the record/replay beat packer.
// Package widths are upper bounds; a packer instance must fit inside them.
package rr_pack_pkg;

  localparam int unsigned DataWidthMax = 32;
  localparam int unsigned RatioMax     = 4;
  localparam int unsigned CntWidthMax  = $clog2(RatioMax + 1);

  typedef logic [CntWidthMax-1:0]           cnt_t;
  typedef logic [DataWidthMax*RatioMax-1:0] beat_t;

  // Clears every dw-wide slot whose index is >= cnt.
  function automatic beat_t zero_unused(input beat_t beat, input cnt_t cnt,
                                        input int unsigned dw);
    beat_t res;
    res = beat;
    for (int unsigned i = 0; i < $bits(beat_t); i++) begin
      if ((i / dw) >= 32'(cnt)) res[i] = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_record_packer.sv
// Packs a narrow valid/ready record stream into wide log beats of RATIO records,
// emitting a partial beat (with slot count and last flag) after a flush request.
module rr_record_packer
  import rr_pack_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RATIO      = 4
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                in_valid,
  input  logic [DATA_WIDTH-1:0]               in_data,
  output logic                                in_ready,
  input  logic                                flush,
  output logic                                out_valid,
  output logic [DATA_WIDTH*RATIO-1:0]         out_data,
  output logic [$clog2(RATIO+1)-1:0]          out_cnt,
  output logic                                out_last,
  input  logic                                out_ready,
  output logic                                idle
);

  localparam int unsigned CNT_WIDTH = $clog2(RATIO + 1);
  localparam int unsigned BW        = DATA_WIDTH * RATIO;
  localparam logic [CNT_WIDTH-1:0] FullCnt = CNT_WIDTH'(RATIO);

  logic [BW-1:0]        acc_q, acc_d;
  logic [CNT_WIDTH-1:0] acc_cnt_q, acc_cnt_d, wr_slot;
  logic                 flush_pend_q, flush_pend_d;
  logic [BW-1:0]        out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;

  logic full, slot_free, emit, insert;

  assign full      = (acc_cnt_q == FullCnt);
  assign slot_free = !out_valid_q || out_ready;
  assign emit      = slot_free && (full || (flush_pend_q && (acc_cnt_q != '0)));
  assign in_ready  = !full || emit;
  assign insert    = in_valid && in_ready;

  always_comb begin
    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;
    wr_slot   = acc_cnt_q;
    if (emit) begin
      acc_d     = '0;
      acc_cnt_d = '0;
      wr_slot   = '0;
    end
    if (insert) begin
      for (int unsigned i = 0; i < RATIO; i++) begin
        if (wr_slot == CNT_WIDTH'(i)) acc_d[i*DATA_WIDTH +: DATA_WIDTH] = in_data;
      end
      acc_cnt_d = wr_slot + 1'b1;
    end
  end

  // A flush with nothing buffered and nothing arriving has no records to close,
  // so it is dropped rather than parked; a pending flush on an empty acc retires.
  always_comb begin
    flush_pend_d = flush_pend_q;
    if (flush_pend_q) begin
      if (emit || (acc_cnt_q == '0)) flush_pend_d = 1'b0;
    end else if (flush && ((acc_cnt_q != '0) || insert)) begin
      flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q        <= '0;
      acc_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_cnt_d   = out_cnt_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    if (emit) begin
      out_data_d  = BW'(zero_unused(beat_t'(acc_q), cnt_t'(acc_cnt_q), DATA_WIDTH));
      out_cnt_d   = acc_cnt_q;
      out_last_d  = flush_pend_q;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_data_q  <= '0;
      out_cnt_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_cnt   = out_cnt_q;
  assign out_last  = out_last_q;
  assign idle      = (acc_cnt_q == '0) && !out_valid_q && !flush_pend_q;

endmodule
